uart_instr_loader: RTL and testbench

Instruction-upload stage between the UART receiver and the DDR2 memory wrapper. It converts the UART byte stream into 32-bit instruction words and writes each word to consecutive memory addresses. Framing comes from the receiver's upload start/end flags. Nibbles are taken LSB-first, words are buffered in a small FIFO, and each write is handshaked against the memory transaction-complete flag.

---
 rtl/uart_instr_loader_if.sv | 41 ++++
 rtl/uart_instr_loader.sv | 259 +++++++++++++++++++++++++
 tb/tb_uart_instr_loader.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_instr_loader_if.sv
// ---------------------------------------------------------------------------
// Module  : uart_instr_loader_if
// Purpose : UART-side framing inputs and memory write bus of the loader.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

interface uart_instr_loader_if #(
  parameter int ADDR_W = 28
);
  logic [7:0]        rx_temp_data;
  logic              rx_done_tick;
  logic              upload_start;
  logic              upload_end;
  logic [ADDR_W-1:0] mem_addr;
  logic [63:0]       mem_d_to_ram;
  logic              write;
  logic              mem_transaction_complete;
  logic              busy;
  logic              done;
  logic [15:0]       word_count;
  logic              overflow;
  logic              partial_err;
  logic              timeout_err;

  modport master (
    input  rx_temp_data, rx_done_tick, upload_start, upload_end,
    input  mem_transaction_complete,
    output mem_addr, mem_d_to_ram, write,
    output busy, done, word_count, overflow, partial_err, timeout_err
  );

  modport slave (
    output rx_temp_data, rx_done_tick, upload_start, upload_end,
    output mem_transaction_complete,
    input  mem_addr, mem_d_to_ram, write,
    input  busy, done, word_count, overflow, partial_err, timeout_err
  );
endinterface

`default_nettype wire

// File: rtl/uart_instr_loader.sv
// ---------------------------------------------------------------------------
// Module  : uart_instr_loader
// Purpose : Packs UART nibbles into 32-bit words and writes them to memory.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module uart_instr_loader #(
  parameter int                ADDR_W     = 28,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
  parameter logic [ADDR_W-1:0] ADDR_STEP  = ADDR_W'(2),
  parameter int                FIFO_DEPTH = 4,
  parameter int                TIMEOUT    = 4096
) (
  input  wire                 CLK100MHZ,
  input  wire                 BTNC,
  uart_instr_loader_if.master bus
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    C_IDLE    = 2'd0,
    C_COLLECT = 2'd1,
    C_DRAIN   = 2'd2
  } cstate_e;

  typedef enum logic [0:0] {
    W_IDLE = 1'b0,
    W_WAIT = 1'b1
  } wstate_e;

  // Edge detectors: each level flag is registered once and compared to its past
  logic       rx_q, start_q, end_q, cmpl_q;
  logic       rx_edge_q, start_edge_q, end_edge_q, cmpl_edge_q;
  logic [3:0] nib_q;
  logic       rx_unused;

  assign rx_unused = ^bus.rx_temp_data[7:4];

  always_ff @(posedge CLK100MHZ) begin
    if (BTNC) begin
      rx_q         <= 1'b0;
      start_q      <= 1'b0;
      end_q        <= 1'b0;
      cmpl_q       <= 1'b0;
      rx_edge_q    <= 1'b0;
      start_edge_q <= 1'b0;
      end_edge_q   <= 1'b0;
      cmpl_edge_q  <= 1'b0;
      nib_q        <= 4'd0;
    end else begin
      rx_q         <= bus.rx_done_tick;
      start_q      <= bus.upload_start;
      end_q        <= bus.upload_end;
      cmpl_q       <= bus.mem_transaction_complete;
      rx_edge_q    <= bus.rx_done_tick & ~rx_q;
      start_edge_q <= bus.upload_start & ~start_q;
      end_edge_q   <= bus.upload_end & ~end_q;
      cmpl_edge_q  <= bus.mem_transaction_complete & ~cmpl_q;
      nib_q        <= bus.rx_temp_data[3:0];
    end
  end

  // State and datapath registers
  cstate_e           cstate_q, cstate_d;
  wstate_e           wstate_q, wstate_d;
  logic [2:0]        idx_q, idx_d;
  logic [31:0]       temp_q, temp_d;
  logic              partial_q, partial_d;
  logic              overflow_q, overflow_d;
  logic              timeout_q, timeout_d;
  logic [TW-1:0]     wait_q, wait_d;
  logic [ADDR_W-1:0] addr_cnt_q, addr_cnt_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [63:0]       mem_data_q, mem_data_d;
  logic              write_q, write_d;
  logic [15:0]       count_q, count_d;
  logic [PW:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [31:0]       fifo_mem_q [FIFO_DEPTH];

  logic              push, pop, push_ok, start_clr, done_w;
  logic              fifo_empty, fifo_full;
  logic [31:0]       push_data, fifo_rdata;

  // Collector FSM
  always_comb begin
    cstate_d  = cstate_q;
    idx_d     = idx_q;
    temp_d    = temp_q;
    partial_d = partial_q;
    push      = 1'b0;
    push_data = {nib_q, temp_q[31:4]};
    start_clr = 1'b0;
    done_w    = 1'b0;
    case (cstate_q)
      C_IDLE: begin
        if (start_edge_q) begin
          cstate_d  = C_COLLECT;
          idx_d     = 3'd0;
          temp_d    = 32'd0;
          partial_d = 1'b0;
          start_clr = 1'b1;
        end
      end
      C_COLLECT: begin
        if (rx_edge_q) begin
          temp_d = push_data;
          if (idx_q == 3'd7) begin
            push  = 1'b1;
            idx_d = 3'd0;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
        // A nibble arriving with the end flag is absorbed before the check
        if (end_edge_q) begin
          cstate_d = C_DRAIN;
          if (idx_d != 3'd0) begin
            partial_d = 1'b1;
          end
        end
      end
      C_DRAIN: begin
        if (fifo_empty && (wstate_q == W_IDLE)) begin
          done_w   = 1'b1;
          cstate_d = C_IDLE;
        end
      end
      default: cstate_d = C_IDLE;
    endcase
  end

  // Word FIFO; a full FIFO still accepts a push when a pop frees a slot
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]) &&
                      (wr_ptr_q[PW] != rd_ptr_q[PW]);
  assign fifo_rdata = fifo_mem_q[rd_ptr_q[PW-1:0]];
  assign push_ok    = push && (!fifo_full || pop);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    if (start_clr) begin
      overflow_d = 1'b0;
    end
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end else if (push) begin
      overflow_d = 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge CLK100MHZ) begin
    if (push_ok) begin
      fifo_mem_q[wr_ptr_q[PW-1:0]] <= push_data;
    end
  end

  // Writer FSM
  always_comb begin
    wstate_d   = wstate_q;
    wait_d     = wait_q;
    addr_cnt_d = addr_cnt_q;
    count_d    = count_q;
    timeout_d  = timeout_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    write_d    = 1'b0;
    pop        = 1'b0;
    if (start_clr) begin
      addr_cnt_d = BASE_ADDR;
      count_d    = 16'd0;
      timeout_d  = 1'b0;
    end
    case (wstate_q)
      W_IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          mem_addr_d = addr_cnt_q;
          mem_data_d = {32'd0, fifo_rdata};
          write_d    = 1'b1;
          wait_d     = '0;
          wstate_d   = W_WAIT;
        end
      end
      W_WAIT: begin
        wait_d = wait_q + TW'(1);
        if (cmpl_edge_q) begin
          if (count_q != 16'hFFFF) begin
            count_d = count_q + 16'd1;
          end
          addr_cnt_d = addr_cnt_q + ADDR_STEP;
          wstate_d   = W_IDLE;
        end else if (wait_q == TW'(TIMEOUT)) begin
          // Give up on this word but keep the address map aligned
          timeout_d  = 1'b1;
          addr_cnt_d = addr_cnt_q + ADDR_STEP;
          wstate_d   = W_IDLE;
        end
      end
      default: wstate_d = W_IDLE;
    endcase
  end

  always_ff @(posedge CLK100MHZ) begin
    if (BTNC) begin
      cstate_q   <= C_IDLE;
      wstate_q   <= W_IDLE;
      idx_q      <= 3'd0;
      temp_q     <= 32'd0;
      partial_q  <= 1'b0;
      overflow_q <= 1'b0;
      timeout_q  <= 1'b0;
      wait_q     <= '0;
      addr_cnt_q <= BASE_ADDR;
      mem_addr_q <= '0;
      mem_data_q <= 64'd0;
      write_q    <= 1'b0;
      count_q    <= 16'd0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      cstate_q   <= cstate_d;
      wstate_q   <= wstate_d;
      idx_q      <= idx_d;
      temp_q     <= temp_d;
      partial_q  <= partial_d;
      overflow_q <= overflow_d;
      timeout_q  <= timeout_d;
      wait_q     <= wait_d;
      addr_cnt_q <= addr_cnt_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      write_q    <= write_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  assign bus.mem_addr     = mem_addr_q;
  assign bus.mem_d_to_ram = mem_data_q;
  assign bus.write        = write_q;
  assign bus.busy         = (cstate_q != C_IDLE);
  assign bus.done         = done_w;
  assign bus.word_count   = count_q;
  assign bus.overflow     = overflow_q;
  assign bus.partial_err  = partial_q;
  assign bus.timeout_err  = timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_instr_loader.sv
// ---------------------------------------------------------------------------
// Module  : tb_uart_instr_loader
// Purpose : Directed self-checking bench for uart_instr_loader.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_uart_instr_loader;

  logic       clk;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_tick, up_start, up_end;
  logic       cmpl_man, cmpl_auto, auto_ack;

  int n_checks = 0;
  int n_errors = 0;

  uart_instr_loader_if #(.ADDR_W(28)) ifa ();
  uart_instr_loader_if #(.ADDR_W(28)) ifb ();

  assign ifa.rx_temp_data             = rx_data;
  assign ifa.rx_done_tick             = rx_tick;
  assign ifa.upload_start             = up_start;
  assign ifa.upload_end               = up_end;
  assign ifa.mem_transaction_complete = cmpl_man | cmpl_auto;
  assign ifb.rx_temp_data             = rx_data;
  assign ifb.rx_done_tick             = rx_tick;
  assign ifb.upload_start             = up_start;
  assign ifb.upload_end               = up_end;
  assign ifb.mem_transaction_complete = 1'b0;

  uart_instr_loader #(
    .ADDR_W(28), .BASE_ADDR(28'd0), .ADDR_STEP(28'd2),
    .FIFO_DEPTH(4), .TIMEOUT(4096)
  ) dut_a (
    .CLK100MHZ(clk), .BTNC(rst), .bus(ifa.master)
  );

  // Second instance never sees a completion, used for the timeout case
  uart_instr_loader #(
    .ADDR_W(28), .BASE_ADDR(28'd0), .ADDR_STEP(28'd2),
    .FIFO_DEPTH(4), .TIMEOUT(16)
  ) dut_b (
    .CLK100MHZ(clk), .BTNC(rst), .bus(ifb.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [27:0] wr_addr [$];
  logic [63:0] wr_data [$];
  int          done_total = 0;

  always @(negedge clk) begin
    if (ifa.write === 1'b1) begin
      wr_addr.push_back(ifa.mem_addr);
      wr_data.push_back(ifa.mem_d_to_ram);
    end
    if (ifa.done === 1'b1) done_total++;
  end

  // Memory model: completion pulse five cycles after each write when enabled
  initial begin
    cmpl_auto = 1'b0;
    forever begin
      @(negedge clk);
      if (auto_ack && ifa.write === 1'b1 && !rst) begin
        repeat (4) @(negedge clk);
        cmpl_auto = 1'b1;
        @(negedge clk);
        cmpl_auto = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic pulse_start();
    up_start = 1'b1; tick();
    up_start = 1'b0; tick();
  endtask

  task automatic pulse_end();
    up_end = 1'b1; tick();
    up_end = 1'b0; tick();
  endtask

  task automatic send_nibble(input logic [3:0] n);
    rx_data = {4'hF, n};
    rx_tick = 1'b1; tick();
    rx_tick = 1'b0; tick();
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 8; i++) send_nibble(w[4*i +: 4]);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (ifa.busy === 1'b1 && n < budget) begin
      tick();
      n++;
    end
    chk(tag, ifa.busy, 1'b0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_addr"}, ifa.mem_addr, 28'd0);
    chk({tag, "_data"}, ifa.mem_d_to_ram, 64'd0);
    chk({tag, "_write"}, ifa.write, 1'b0);
    chk({tag, "_busy"}, ifa.busy, 1'b0);
    chk({tag, "_done"}, ifa.done, 1'b0);
    chk({tag, "_wcnt"}, ifa.word_count, 16'd0);
    chk({tag, "_ovf"}, ifa.overflow, 1'b0);
    chk({tag, "_part"}, ifa.partial_err, 1'b0);
    chk({tag, "_tmo"}, ifa.timeout_err, 1'b0);
  endtask

  initial begin
    int base;
    int dbase;
    int n;
    logic [31:0] words [6];
    words[0] = 32'hDEADBEEF; words[1] = 32'h01234567; words[2] = 32'hCAFEF00D;
    words[3] = 32'h13579BDF; words[4] = 32'h2468ACE0; words[5] = 32'hFFFF0001;
    rst = 1'b1; rx_data = 8'd0; rx_tick = 1'b0; up_start = 1'b0; up_end = 1'b0;
    cmpl_man = 1'b0; auto_ack = 1'b0;
    repeat (3) tick();
    chk_reset_outputs("rst");
    rst = 1'b0;
    tick();

    // Single word 1..8 with exact write latency
    base = wr_addr.size(); dbase = done_total;
    pulse_start();
    chk("t1_busy_up", ifa.busy, 1'b1);
    for (int i = 1; i <= 7; i++) send_nibble(4'(i));
    send_nibble(4'd8);
    chk("t1_write_early", ifa.write, 1'b0);
    tick();
    chk("t1_write", ifa.write, 1'b1);
    chk("t1_addr", ifa.mem_addr, 28'd0);
    chk("t1_data", ifa.mem_d_to_ram, 64'h0000_0000_8765_4321);
    tick();
    chk("t1_write_pulse", ifa.write, 1'b0);
    pulse_end();
    repeat (2) tick();
    cmpl_man = 1'b1; tick();
    cmpl_man = 1'b0;
    n = 0;
    while (ifa.done !== 1'b1 && n < 50) begin tick(); n++; end
    chk("t1_done_seen", ifa.done, 1'b1);
    chk("t1_busy_at_done", ifa.busy, 1'b1);
    tick();
    chk("t1_busy_after", ifa.busy, 1'b0);
    chk("t1_done_pulse", ifa.done, 1'b0);
    chk("t1_wcnt", ifa.word_count, 16'd1);
    chk("t1_nwr", wr_addr.size() - base, 1);
    chk("t1_ndone", done_total - dbase, 1);

    // Three words back to back with auto completion
    auto_ack = 1'b1;
    base = wr_addr.size();
    pulse_start();
    for (int i = 0; i < 3; i++) send_word(words[i]);
    pulse_end();
    wait_idle("t2_idle", 300);
    chk("t2_nwr", wr_addr.size() - base, 3);
    for (int i = 0; i < 3; i++) begin
      if (wr_addr.size() > base + i) begin
        chk($sformatf("t2_addr%0d", i), wr_addr[base+i], 28'(2*i));
        chk($sformatf("t2_data%0d", i), wr_data[base+i], {32'd0, words[i]});
      end
    end
    chk("t2_wcnt", ifa.word_count, 16'd3);

    // Overflow: completion held low while six words arrive
    auto_ack = 1'b0;
    base = wr_addr.size();
    pulse_start();
    for (int i = 0; i < 5; i++) send_word(words[i]);
    chk("t3_ovf_full", ifa.overflow, 1'b0);
    send_word(words[5]);
    tick();
    chk("t3_ovf", ifa.overflow, 1'b1);
    chk("t3_nwr_held", wr_addr.size() - base, 1);
    pulse_end();
    cmpl_man = 1'b1; tick();
    cmpl_man = 1'b0;
    auto_ack = 1'b1;
    wait_idle("t3_idle", 300);
    chk("t3_nwr", wr_addr.size() - base, 5);
    if (wr_addr.size() >= base + 5) begin
      chk("t3_last_addr", wr_addr[base+4], 28'd8);
      chk("t3_last_data", wr_data[base+4], {32'd0, words[4]});
    end
    chk("t3_wcnt", ifa.word_count, 16'd5);
    chk("t3_ovf_sticky", ifa.overflow, 1'b1);

    // Eleven nibbles: one word plus a discarded partial
    base = wr_addr.size(); dbase = done_total;
    pulse_start();
    chk("t4_ovf_clr", ifa.overflow, 1'b0);
    for (int i = 1; i <= 11; i++) send_nibble(4'(i));
    pulse_end();
    wait_idle("t4_idle", 100);
    chk("t4_nwr", wr_addr.size() - base, 1);
    if (wr_addr.size() > base) chk("t4_data", wr_data[base], 64'h0000_0000_8765_4321);
    chk("t4_part", ifa.partial_err, 1'b1);
    chk("t4_ndone", done_total - dbase, 1);

    // Eighth nibble and upload_end in the same cycle
    base = wr_addr.size();
    pulse_start();
    chk("t4b_part_clr", ifa.partial_err, 1'b0);
    for (int i = 1; i <= 7; i++) send_nibble(4'(i));
    rx_data = 8'h08; rx_tick = 1'b1; up_end = 1'b1; tick();
    rx_tick = 1'b0; up_end = 1'b0; tick();
    wait_idle("t4b_idle", 100);
    chk("t4b_nwr", wr_addr.size() - base, 1);
    if (wr_addr.size() > base) chk("t4b_data", wr_data[base], 64'h0000_0000_8765_4321);
    chk("t4b_part", ifa.partial_err, 1'b0);

    // Timeout on the instance without completions
    auto_ack = 1'b0;
    do_reset();
    pulse_start();
    send_word(32'hA5A5_5A5A);
    tick();
    chk("t5_write", ifb.write, 1'b1);
    chk("t5_addr0", ifb.mem_addr, 28'd0);
    repeat (16) tick();
    chk("t5_tmo_early", ifb.timeout_err, 1'b0);
    tick();
    chk("t5_tmo", ifb.timeout_err, 1'b1);
    chk("t5_wcnt", ifb.word_count, 16'd0);
    send_word(32'h0BAD_CAFE);
    n = 0;
    while (ifb.write !== 1'b1 && n < 20) begin tick(); n++; end
    chk("t5_write2", ifb.write, 1'b1);
    chk("t5_addr1", ifb.mem_addr, 28'd2);
    chk("t5_data1", ifb.mem_d_to_ram, 64'h0000_0000_0BAD_CAFE);
    pulse_end();

    // Reset during W_WAIT with two words buffered
    do_reset();
    pulse_start();
    for (int i = 0; i < 3; i++) send_word(words[i]);
    rst = 1'b1; tick();
    chk_reset_outputs("t6");
    rst = 1'b0; tick();
    base = wr_addr.size();
    cmpl_man = 1'b1; tick();
    cmpl_man = 1'b0;
    repeat (10) tick();
    chk("t6_nwr", wr_addr.size() - base, 0);
    chk("t6_wcnt", ifa.word_count, 16'd0);
    chk("t6_busy", ifa.busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
